array_wrctl: RTL and testbench
==============================

Name: array_wrctl

Overview:
- Write-side controller for the 1-write/2-read register arrays that hold per-channel state in the STM1/E1 datapath.
- Owns the single array write port.
- After reset, or on request, sweeps the whole array to an init value.
- In normal operation it merges two write requesters (A = framer/datapath, B = CPU/config) onto the write port, with bounded wait for B.

Parameters:
ADDRBIT, 9, width of address buses
DEPTH, 512, number of valid array words (addresses 0..DEPTH-1)
WIDTH, 32, data width
INITVAL, 0, word written to every address during init sweep

Ports:
clk  in  1  single clock; drives array write clock
rst_  in  1  asynchronous active-low reset
init_req  in  1  one-cycle pulse: start or restart the init sweep
req_a  in  1  requester A write request; held until ack_a
addr_a  in  ADDRBIT  requester A address
data_a  in  WIDTH  requester A data
ack_a  out  1  grant to A (combinational, same cycle as accepted req_a)
req_b  in  1  requester B write request; held until ack_b
addr_b  in  ADDRBIT  requester B address
data_b  in  WIDTH  requester B data
ack_b  out  1  grant to B (combinational)
wa  out  ADDRBIT  array write address (registered)
we  out  1  array write enable (registered)
di  out  WIDTH  array write data (registered)
init_done  out  1  high once a sweep has completed, low while sweeping
err_oor  out  1  sticky: a granted request had address >= DEPTH

Behaviour:
- Reset values:
  - wa=0, we=0, di=0, init_done=0, err_oor=0.
  - State=INIT, sweep counter=0, B-denied flag=0.
- Reset entry/exit:
  - Reset asserted mid-operation aborts everything; no partial write is emitted after rst_ falls.
  - A sweep starts automatically on the first clock after rst_ rises.
- States:
  - INIT: each cycle registers we=1, wa=cnt, di=INITVAL, then cnt++.
    - After the cycle issuing wa=DEPTH-1: go to RUN, init_done=1 (init_done rises in the same cycle that write appears on we).
    - Exactly DEPTH writes per sweep.
    - ack_a=ack_b=0 throughout; requests stay pending.
  - RUN: arbitrate; on a grant, register we=1 and the winner's addr/data on the next edge (1-cycle latency, req to we). With no grant, we=0 and wa/di hold their last value.
- init_req:
  - In RUN: no grant that cycle; next state INIT; cnt=0; init_done=0; err_oor cleared.
  - In INIT: restarts the sweep at address 0.
  - Takes precedence over any request in the same cycle.
- Arbitration (RUN only):
  - Only req_a: grant A. Only req_b: grant B.
  - Both: grant A unless the B-denied flag is set, then grant B.
  - B-denied flag is set when req_b was high and not granted; cleared when B is granted.
  - Net effect: B waits at most 1 cycle under continuous A traffic; A waits at most 1 cycle.
  - At most one ack per cycle.
- Out-of-range address (>= DEPTH, only possible when DEPTH < 2^ADDRBIT):
  - Request is still acked but dropped (we=0 that cycle).
  - err_oor set to 1, sticky until reset or init_req.
- Counter arithmetic: cnt is ADDRBIT wide; compare against DEPTH-1; no wrap beyond DEPTH.
- Simultaneous init_req with ack conditions: no ack is issued.
- Requester contract: deassert req or change addr/data only in the cycle after ack.

Decomposition:
- Shared package/include array_wrctl_pkg:
  - State encoding constants ST_INIT, ST_RUN.
  - Grant select codes GNT_NONE, GNT_A, GNT_B.
- One natural sub-module: wrarb2.
  - Combinational 2-way arbiter plus the B-denied flop.
  - Inputs: req_a, req_b, enable. Outputs: gnt_a, gnt_b.
- Sweep counter, state register and write-port registers stay in the top.

Test Plan:
- Reset release, DEPTH=512, no requests:
  - we high for exactly 512 consecutive cycles, wa 0..511, di=0.
  - init_done rises with the wa=511 write.
- req_a held during sweep:
  - ack_a stays 0 until RUN.
  - First RUN cycle: ack_a=1, then next cycle we=1 with wa/di=addr_a/data_a.
- req_a and req_b both held high for 6 grants:
  - Grants alternate A,B,A,B,A,B.
  - Each ack followed one cycle later by the matching write.
- DEPTH=300, ADDRBIT=9, req_b with addr_b=400:
  - ack_b=1, no we pulse, err_oor=1.
  - A later init_req clears err_oor.
- init_req at sweep address 100:
  - Next writes restart at wa=0.
  - 512 further writes before init_done=1.
- rst_ low during a granted write cycle:
  - we, init_done, err_oor go 0 immediately (asynchronously).
  - After release, a full sweep from 0 occurs.

Source files
------------

// File: rtl/array_wrctl_pkg.sv
// array_wrctl shared types: controller state
// and arbiter grant-select codes.
package array_wrctl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } gnt_e;

endpackage

// File: rtl/array_wrctl_wrarb.sv
// wrarb2: two-way write arbiter, A preferred,
// B never loses twice in a row.
// Ports: clk, rst_ (async low), req_a/req_b,
//   enable (arbitration allowed), gnt_a/gnt_b.
module wrarb2 (
  input  logic clk,
  input  logic rst_,
  input  logic req_a,
  input  logic req_b,
  input  logic enable,
  output logic gnt_a,
  output logic gnt_b
);

  logic bden_q, bden_d;

  // bden_q: B asked last cycle and lost,
  // so B wins the next tie.
  always_comb begin
    gnt_a  = enable & req_a
           & ~(req_b & bden_q);
    gnt_b  = enable & req_b
           & (~req_a | bden_q);
    bden_d = bden_q;
    if (gnt_b)
      bden_d = 1'b0;
    else if (req_b)
      bden_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      bden_q <= 1'b0;
    else
      bden_q <= bden_d;
  end

endmodule

// File: rtl/array_wrctl.sv
// array_wrctl: owns the array write port; init
// sweep after reset/init_req, then merges A/B.
// Ports: clk, rst_, init_req, req/addr/data/ack
//   for A and B, wa/we/di to the array,
//   init_done, err_oor (sticky bad address).
module array_wrctl
  import array_wrctl_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512,
  parameter int WIDTH   = 32,
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               init_req,
  input  logic               req_a,
  input  logic [ADDRBIT-1:0] addr_a,
  input  logic [WIDTH-1:0]   data_a,
  output logic               ack_a,
  input  logic               req_b,
  input  logic [ADDRBIT-1:0] addr_b,
  input  logic [WIDTH-1:0]   data_b,
  output logic               ack_b,
  output logic [ADDRBIT-1:0] wa,
  output logic               we,
  output logic [WIDTH-1:0]   di,
  output logic               init_done,
  output logic               err_oor
);

  localparam logic [ADDRBIT-1:0] LAST =
    ADDRBIT'(DEPTH - 1);
  localparam logic [ADDRBIT:0] DEP =
    (ADDRBIT + 1)'(DEPTH);

  state_e               st_q, st_d;
  logic [ADDRBIT-1:0]   cnt_q, cnt_d;
  logic [ADDRBIT-1:0]   wa_q, wa_d;
  logic                 we_q, we_d;
  logic [WIDTH-1:0]     di_q, di_d;
  logic                 done_q, done_d;
  logic                 oor_q, oor_d;

  logic                 en;
  logic                 gnt_a, gnt_b;
  gnt_e                 gsel;
  logic [ADDRBIT-1:0]   gaddr;
  logic [WIDTH-1:0]     gdata;

  // init_req wins over any request this cycle
  assign en = (st_q == ST_RUN) & ~init_req;

  wrarb2 u_arb (
    .clk    (clk),
    .rst_   (rst_),
    .req_a  (req_a),
    .req_b  (req_b),
    .enable (en),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  assign ack_a = gnt_a;
  assign ack_b = gnt_b;

  always_comb begin
    gsel  = GNT_NONE;
    gaddr = '0;
    gdata = '0;
    unique case (1'b1)
      gnt_a:   gsel = GNT_A;
      gnt_b:   gsel = GNT_B;
      default: gsel = GNT_NONE;
    endcase
    case (gsel)
      GNT_A: begin
        gaddr = addr_a;
        gdata = data_a;
      end
      GNT_B: begin
        gaddr = addr_b;
        gdata = data_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    wa_d   = wa_q;
    we_d   = 1'b0;
    di_d   = di_q;
    done_d = done_q;
    oor_d  = oor_q;
    if (init_req) begin
      st_d   = ST_INIT;
      cnt_d  = '0;
      done_d = 1'b0;
      oor_d  = 1'b0;
    end else if (st_q == ST_INIT) begin
      we_d = 1'b1;
      wa_d = cnt_q;
      di_d = INITVAL;
      if (cnt_q == LAST) begin
        st_d   = ST_RUN;
        done_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (gsel != GNT_NONE) begin
      // bad address: acked but dropped
      if ({1'b0, gaddr} < DEP) begin
        we_d = 1'b1;
        wa_d = gaddr;
        di_d = gdata;
      end else begin
        oor_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      st_q   <= ST_INIT;
      cnt_q  <= '0;
      wa_q   <= '0;
      we_q   <= 1'b0;
      di_q   <= '0;
      done_q <= 1'b0;
      oor_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      wa_q   <= wa_d;
      we_q   <= we_d;
      di_q   <= di_d;
      done_q <= done_d;
      oor_q  <= oor_d;
    end
  end

  assign wa        = wa_q;
  assign we        = we_q;
  assign di        = di_q;
  assign init_done = done_q;
  assign err_oor   = oor_q;

endmodule

// File: tb/tb_array_wrctl.sv
// Bench for array_wrctl: DEPTH=512 and a
// DEPTH=300 instance, directed + random traffic.
module tb_array_wrctl;

  localparam logic [31:0] IV1 = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst_;
  int          checks = 0;
  int          errors = 0;

  logic        init0, rqa0, rqb0, aka0, akb0;
  logic [8:0]  ada0, adb0, wa0;
  logic [31:0] dta0, dtb0, di0;
  logic        we0, dn0, er0;

  logic        init1, rqa1, rqb1, aka1, akb1;
  logic [8:0]  ada1, adb1, wa1;
  logic [31:0] dta1, dtb1, di1;
  logic        we1, dn1, er1;

  always #5 clk = ~clk;

  array_wrctl #(
    .ADDRBIT(9), .DEPTH(512), .WIDTH(32),
    .INITVAL(32'h0)
  ) u0 (
    .clk(clk), .rst_(rst_), .init_req(init0),
    .req_a(rqa0), .addr_a(ada0),
    .data_a(dta0), .ack_a(aka0),
    .req_b(rqb0), .addr_b(adb0),
    .data_b(dtb0), .ack_b(akb0),
    .wa(wa0), .we(we0), .di(di0),
    .init_done(dn0), .err_oor(er0)
  );

  array_wrctl #(
    .ADDRBIT(9), .DEPTH(300), .WIDTH(32),
    .INITVAL(IV1)
  ) u1 (
    .clk(clk), .rst_(rst_), .init_req(init1),
    .req_a(rqa1), .addr_a(ada1),
    .data_a(dta1), .ack_a(aka1),
    .req_b(rqb1), .addr_b(adb1),
    .data_b(dtb1), .ack_b(akb1),
    .wa(wa1), .we(we1), .di(di1),
    .init_done(dn1), .err_oor(er1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full u0 sweep: writes 0..511 of zero,
  // back to back, done only with the last
  task automatic sweep0(input string tag);
    for (int i = 0; i < 512; i++) begin
      chk({tag, "_ack"}, {aka0, akb0}, 2'b00);
      tick();
      chk({tag, "_we"}, we0, 1'b1);
      chk({tag, "_wa"}, wa0, i);
      chk({tag, "_di"}, di0, 0);
      chk({tag, "_done"}, dn0, i == 511);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0]  ea;
    logic [31:0] ed;
    logic        pa, pb, bw, ga, gb;
    logic [8:0]  la;
    logic [31:0] ld;
    int          n;

    init0 = 0; rqb0 = 0; adb0 = 0; dtb0 = 0;
    init1 = 0; rqa1 = 0; ada1 = 0; dta1 = 0;
    rqb1 = 0; adb1 = 0; dtb1 = 0;
    rqa0 = 1;
    ada0 = 9'($urandom_range(0, 511));
    dta0 = $urandom;
    rst_ = 1;
    #2 rst_ = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", we0, 1'b0);
    chk("rst_wa", wa0, 0);
    chk("rst_di", di0, 0);
    chk("rst_done", dn0, 1'b0);
    chk("rst_oor", er0, 1'b0);
    chk("rst_done1", dn1, 1'b0);

    // sweep after reset, A pending meanwhile
    rst_ = 1;
    sweep0("sw0");
    chk("sw0_u1_done", dn1, 1'b1);
    chk("sw0_u1_we", we1, 1'b0);
    chk("sw0_u1_wa", wa1, 299);
    chk("sw0_u1_di", di1, IV1);

    // first RUN cycle grants the held A
    chk("runA_ack", aka0, 1'b1);
    ea = ada0; ed = dta0;
    tick();
    rqa0 = 0;
    chk("runA_we", we0, 1'b1);
    chk("runA_wa", wa0, ea);
    chk("runA_di", di0, ed);
    #1 chk("runA_ack0", aka0, 1'b0);
    tick();
    chk("idle_we", we0, 1'b0);
    chk("idle_wa", wa0, ea);
    chk("idle_di", di0, ed);

    // both held: grants alternate A,B,A,B,...
    rqa0 = 1; rqb0 = 1;
    ada0 = 9'($urandom_range(0, 511));
    dta0 = $urandom;
    adb0 = 9'($urandom_range(0, 511));
    dtb0 = $urandom;
    for (int k = 0; k < 6; k++) begin
      #1;
      ga = (k % 2) == 0;
      chk("alt_ackA", aka0, ga);
      chk("alt_ackB", akb0, !ga);
      ea = ga ? ada0 : adb0;
      ed = ga ? dta0 : dtb0;
      tick();
      chk("alt_we", we0, 1'b1);
      chk("alt_wa", wa0, ea);
      chk("alt_di", di0, ed);
      if (ga) begin
        ada0 = 9'($urandom_range(0, 511));
        dta0 = $urandom;
      end else begin
        adb0 = 9'($urandom_range(0, 511));
        dtb0 = $urandom;
      end
    end
    rqa0 = 0; rqb0 = 0;
    tick();
    chk("alt_end_we", we0, 1'b0);
    la = wa0; ld = di0;

    // random traffic against a fairness model:
    // a tie goes to A unless B lost last cycle
    pa = 0; pb = 0; bw = 0;
    for (int c = 0; c < 44; c++) begin
      if (c < 40 && !pa && $urandom_range(0, 1)) begin
        pa = 1;
        ada0 = 9'($urandom_range(0, 511));
        dta0 = $urandom;
      end
      if (c < 40 && !pb && $urandom_range(0, 1)) begin
        pb = 1;
        adb0 = 9'($urandom_range(0, 511));
        dtb0 = $urandom;
      end
      rqa0 = pa; rqb0 = pb;
      #1;
      ga = pa && !(pb && bw);
      gb = pb && !ga;
      chk("rnd_ackA", aka0, ga);
      chk("rnd_ackB", akb0, gb);
      if (ga) begin la = ada0; ld = dta0; end
      if (gb) begin la = adb0; ld = dtb0; end
      tick();
      chk("rnd_we", we0, ga | gb);
      chk("rnd_wa", wa0, la);
      chk("rnd_di", di0, ld);
      bw = pb && !gb;
      if (ga) pa = 0;
      if (gb) pb = 0;
      rqa0 = pa; rqb0 = pb;
    end
    rqa0 = 0; rqb0 = 0;

    // DEPTH=300: out-of-range B acked, dropped
    rqb1 = 1; adb1 = 400; dtb1 = $urandom;
    #1 chk("oor_ack", akb1, 1'b1);
    tick();
    rqb1 = 0;
    chk("oor_we", we1, 1'b0);
    chk("oor_err", er1, 1'b1);
    rqa1 = 1; ada1 = 299; dta1 = $urandom;
    #1 chk("edge_ack", aka1, 1'b1);
    ed = dta1;
    tick();
    chk("edge_we", we1, 1'b1);
    chk("edge_wa", wa1, 299);
    chk("edge_di", di1, ed);
    chk("oor_sticky", er1, 1'b1);
    // init_req beats a pending request
    ada1 = 5; dta1 = $urandom;
    init1 = 1;
    #1 chk("ireq_ack", aka1, 1'b0);
    tick();
    init1 = 0;
    chk("ireq_err", er1, 1'b0);
    chk("ireq_done", dn1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      chk("sw1_ack", aka1, 1'b0);
      tick();
      chk("sw1_we", we1, 1'b1);
      chk("sw1_wa", wa1, i);
      chk("sw1_di", di1, IV1);
      chk("sw1_done", dn1, i == 299);
    end
    chk("sw1_ackA", aka1, 1'b1);
    ed = dta1;
    tick();
    rqa1 = 0;
    chk("sw1_A_we", we1, 1'b1);
    chk("sw1_A_wa", wa1, 5);
    chk("sw1_A_di", di1, ed);

    // u0: sweep restart at address 100
    init0 = 1;
    tick();
    init0 = 0;
    chk("rs_done0", dn0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("rs_pre_wa", wa0, i);
    end
    init0 = 1;
    tick();
    init0 = 0;
    n = 0;
    while (we0 !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    chk("rs_first_we", we0, 1'b1);
    chk("rs_first_wa", wa0, 0);
    chk("rs_first_done", dn0, 1'b0);
    for (int i = 1; i < 512; i++) begin
      tick();
      chk("rs_we", we0, 1'b1);
      chk("rs_wa", wa0, i);
      chk("rs_done", dn0, i == 511);
    end
    tick();

    // async reset in the middle of writes
    rqa0 = 1;
    ada0 = 9'($urandom_range(1, 511));
    dta0 = $urandom;
    rqb1 = 1; adb1 = 450; dtb1 = $urandom;
    #1;
    chk("ar_ackA", aka0, 1'b1);
    chk("ar_ackB1", akb1, 1'b1);
    ea = ada0;
    tick();
    rqa0 = 0; rqb1 = 0;
    chk("ar_we", we0, 1'b1);
    chk("ar_wa", wa0, ea);
    chk("ar_err1", er1, 1'b1);
    #2 rst_ = 0;
    #1;
    chk("ar_we0", we0, 1'b0);
    chk("ar_wa0", wa0, 0);
    chk("ar_done0", dn0, 1'b0);
    chk("ar_err1c", er1, 1'b0);
    chk("ar_done1", dn1, 1'b0);
    tick();
    tick();
    chk("ar_hold_we", we0, 1'b0);
    rst_ = 1;
    sweep0("sw2");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
